// File: rtl/sense_controller.sv
// -----------------------------------------------------------------------------
// sense_controller
//
// Purpose:
//   Sequences humidity/temperature sensor reads on behalf of a decoded command
//   stream. It supports single-shot reads and continuous reads that repeat
//   after an idle gap. Each result goes to a transmitter as one 16-bit
//   response word over a valid/ready handshake. A break command stops
//   continuous sensing and is answered with a confirmation word.
//
// Optional feature:
//   SENSE_TIMEOUT_EN - when defined, a wait for the sensor that lasts
//   TIMEOUT_CYCLES cycles ends with an error response (0x1F00).
//
// Parameters:
//   PERIOD_CYCLES      idle gap in cycles between continuous measurements
//   TIMEOUT_CYCLES     max cycles spent waiting for sensor_done_i
//
// Ports:
//   clk_i              sole clock, rising edge
//   rst_n_i            synchronous active-low reset
//   cmd_valid_i        one-cycle pulse, decoded instruction present
//   continuous_en_i    instruction starts continuous sensing
//   break_continuous_i instruction stops continuous sensing
//   data_type_i[1:0]   01 temp, 10 humid, 11 status, 00 none
//   sensor_start_o     one-cycle pulse requesting a sensor read
//   sensor_done_i      one-cycle pulse, sensor_data_i valid
//   sensor_data_i[39:0] humid int/dec, temp int/dec, checksum
//   tx_valid_o         response word valid
//   tx_ready_i         transmitter accepts word
//   tx_data_o[15:0]    [15:8] response code, [7:0] value
//   busy_o             high in any state except IDLE and HOLD
//   cont_active_o      continuous mode armed
// -----------------------------------------------------------------------------
module sense_controller #(
    parameter int PERIOD_CYCLES  = 50000000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        cmd_valid_i,
    input  logic        continuous_en_i,
    input  logic        break_continuous_i,
    input  logic [1:0]  data_type_i,
    output logic        sensor_start_o,
    input  logic        sensor_done_i,
    input  logic [39:0] sensor_data_i,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [15:0] tx_data_o,
    output logic        busy_o,
    output logic        cont_active_o
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_SENSOR,
        SEND,
        HOLD
    } state_t;

    localparam int PW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES + 1) : 1;

    state_t         state_q, state_d;
    logic [1:0]     type_q, type_d;
    logic           cont_q, cont_d;
    logic           cont_active_q, cont_active_d;
    logic           break_pending_q, break_pending_d;
    // The word in flight is the last one of this command; return to IDLE after it.
    logic           final_q, final_d;
    logic           tx_valid_q, tx_valid_d;
    logic [15:0]    tx_data_q, tx_data_d;
    logic [PW-1:0]  period_cnt_q, period_cnt_d;

    logic           is_break;
    logic [7:0]     sum;
    logic           checksum_ok;
    logic [15:0]    resp_word;
    logic           resp_error;
    logic           timeout_hit;

    assign is_break = cmd_valid_i & break_continuous_i;

    // The checksum is the 8-bit wrap-around sum of the four payload bytes.
    assign sum = sensor_data_i[39:32] + sensor_data_i[31:24]
               + sensor_data_i[23:16] + sensor_data_i[15:8];
    assign checksum_ok = (sum == sensor_data_i[7:0]);

`ifdef SENSE_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [TW-1:0]  timeout_cnt_q, timeout_cnt_d;

    // Counts the cycles spent in WAIT_SENSOR; cleared everywhere else.
    assign timeout_cnt_d = (state_q == WAIT_SENSOR) ? timeout_cnt_q + 1'b1 : '0;
    assign timeout_hit   = (timeout_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            timeout_cnt_q <= '0;
        end else begin
            timeout_cnt_q <= timeout_cnt_d;
        end
    end
`else
    // Without the timeout feature the parameter has no effect and the wait
    // for the sensor ends only on sensor_done_i or reset.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    function automatic logic [15:0] confirmWord(input logic [1:0] t);
        case (t)
            2'b01:   confirmWord = 16'h0A00;
            2'b10:   confirmWord = 16'h0B00;
            default: confirmWord = 16'h0F00;
        endcase
    endfunction

    // Builds the response word for the sample presented on sensor_data_i.
    always_comb begin
        resp_word  = 16'h1F00;
        resp_error = 1'b1;
        if (checksum_ok) begin
            case (type_q)
                2'b01: begin
                    resp_word  = {(cont_q ? 8'h0D : 8'h09), sensor_data_i[23:16]};
                    resp_error = 1'b0;
                end
                2'b10: begin
                    resp_word  = {(cont_q ? 8'h0E : 8'h08), sensor_data_i[39:32]};
                    resp_error = 1'b0;
                end
                2'b11: begin
                    resp_word  = 16'h0700;
                    resp_error = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic. A pending break makes SEND drop tx_valid for one cycle
    // after the data word and then load the confirmation word.
    always_comb begin
        state_d         = state_q;
        type_d          = type_q;
        cont_d          = cont_q;
        cont_active_d   = cont_active_q;
        break_pending_d = break_pending_q;
        final_d         = final_q;
        tx_valid_d      = tx_valid_q;
        tx_data_d       = tx_data_q;
        period_cnt_d    = '0;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    if (break_continuous_i) begin
                        tx_data_d  = 16'h0F00;
                        tx_valid_d = 1'b1;
                        final_d    = 1'b1;
                        state_d    = SEND;
                    end else if (data_type_i != 2'b00) begin
                        type_d          = data_type_i;
                        cont_d          = continuous_en_i;
                        break_pending_d = 1'b0;
                        state_d         = START;
                    end
                end
            end
            START: begin
                if (is_break && cont_q) begin
                    break_pending_d = 1'b1;
                end
                state_d = WAIT_SENSOR;
            end
            WAIT_SENSOR: begin
                if (is_break && cont_q) begin
                    break_pending_d = 1'b1;
                end
                if (sensor_done_i) begin
                    tx_data_d  = resp_word;
                    tx_valid_d = 1'b1;
                    final_d    = resp_error | ~cont_q;
                    state_d    = SEND;
                end else if (timeout_hit) begin
                    tx_data_d  = 16'h1F00;
                    tx_valid_d = 1'b1;
                    final_d    = 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (tx_valid_q) begin
                    if (is_break && cont_q && !final_q) begin
                        break_pending_d = 1'b1;
                    end
                    if (tx_ready_i) begin
                        tx_valid_d = 1'b0;
                        if (final_q) begin
                            cont_d          = 1'b0;
                            cont_active_d   = 1'b0;
                            break_pending_d = 1'b0;
                            state_d         = IDLE;
                        end else if (!(break_pending_q || (is_break && cont_q))) begin
                            cont_active_d = 1'b1;
                            state_d       = HOLD;
                        end
                    end
                end else begin
                    tx_data_d       = confirmWord(type_q);
                    tx_valid_d      = 1'b1;
                    final_d         = 1'b1;
                    break_pending_d = 1'b0;
                    cont_active_d   = 1'b0;
                end
            end
            HOLD: begin
                period_cnt_d = period_cnt_q + 1'b1;
                if (is_break) begin
                    tx_data_d     = confirmWord(type_q);
                    tx_valid_d    = 1'b1;
                    final_d       = 1'b1;
                    cont_active_d = 1'b0;
                    state_d       = SEND;
                end else if (period_cnt_q == PW'(PERIOD_CYCLES - 1)) begin
                    period_cnt_d = '0;
                    state_d      = START;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any measurement or handshake in progress.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q         <= IDLE;
            type_q          <= 2'b00;
            cont_q          <= 1'b0;
            cont_active_q   <= 1'b0;
            break_pending_q <= 1'b0;
            final_q         <= 1'b0;
            tx_valid_q      <= 1'b0;
            tx_data_q       <= 16'h0000;
            period_cnt_q    <= '0;
        end else begin
            state_q         <= state_d;
            type_q          <= type_d;
            cont_q          <= cont_d;
            cont_active_q   <= cont_active_d;
            break_pending_q <= break_pending_d;
            final_q         <= final_d;
            tx_valid_q      <= tx_valid_d;
            tx_data_q       <= tx_data_d;
            period_cnt_q    <= period_cnt_d;
        end
    end

    assign sensor_start_o = (state_q == START);
    assign busy_o         = (state_q != IDLE) && (state_q != HOLD);
    assign tx_valid_o     = tx_valid_q;
    assign tx_data_o      = tx_data_q;
    assign cont_active_o  = cont_active_q;

endmodule
